// File: rtl/counter_updown_mod.sv
// rtl/counter_updown_mod.sv - modulo up/down counter with prescaler, wrap/saturate bounds and terminal-count pulse
module counter_updown_mod #(
  parameter int N        = 32,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         dec,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic [N-1:0] max_value,
  output logic [N-1:0] counterN,
  output logic         tc,
  output logic         at_max,
  output logic         at_zero
);

  logic         advance;
  logic [N-1:0] load_clamped;
  logic [N-1:0] next_cnt;
  logic         next_tc;

  generate
    if (PRESCALE == 1) begin : g_nopresc
      assign advance = enable;
    end else begin : g_presc
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
      logic [PW-1:0] presc;

      always_ff @(posedge clock) begin
        if (reset || load) begin
          presc <= '0;
        end else if (enable) begin
          presc <= (presc == PLAST) ? '0 : presc + PW'(1);
        end
      end

      assign advance = enable && (presc == PLAST);
    end
  endgenerate

  assign load_clamped = (load_value > max_value) ? max_value : load_value;

  always_comb begin
    next_cnt = counterN;
    next_tc  = 1'b0;
    if (load) begin
      next_cnt = load_clamped;
    end else if (advance) begin
      if (!dec) begin
        if (counterN < max_value) begin
          next_cnt = counterN + N'(1);
        end else begin
          next_tc  = 1'b1;
          next_cnt = (SATURATE != 0) ? max_value : '0;
        end
      end else begin
        // A limit lowered below the count pulls it back in range without a bound event.
        if (counterN > max_value) begin
          next_cnt = max_value;
        end else if (counterN == '0) begin
          next_tc  = 1'b1;
          next_cnt = (SATURATE != 0) ? '0 : max_value;
        end else begin
          next_cnt = counterN - N'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      counterN <= '0;
      tc       <= 1'b0;
    end else begin
      counterN <= next_cnt;
      tc       <= next_tc;
    end
  end

  assign at_max  = (counterN >= max_value);
  assign at_zero = (counterN == '0);

endmodule
